// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order request FIFO feeding a combinational ALU, with a registered result slot.
// Optional statistics counters are enabled with ALU_ISSUE_STATS_EN.
module alu_issue_queue #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       ops_done,
    output logic [15:0]       stall_cycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] a_mem_q [DEPTH];
    logic [DATA_W-1:0] b_mem_q [DEPTH];
    logic [OP_W-1:0]   op_mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]   res_op_q, res_op_d;
    logic              has_head, push, load;

    // Handshakes, queue bookkeeping and result-slot update; flush overrides normal flow.
    always_comb begin
        has_head    = count_q != '0;
        in_ready    = !rst && !flush && (count_q < FULL);
        push        = in_valid && in_ready;
        load        = !flush && has_head && (!res_valid_q || res_ready);
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(load);
        wr_ptr_d    = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + PW'(load);
        res_valid_d = flush ? 1'b0 : load ? 1'b1 : res_valid_q && !res_ready;
        res_data_d  = load ? alu_out : res_data_q;
        res_op_d    = load ? op_mem_q[rd_ptr_q] : res_op_q;
        alu_a       = has_head ? a_mem_q[rd_ptr_q] : '0;
        alu_b       = has_head ? b_mem_q[rd_ptr_q] : '0;
        alu_op      = has_head ? op_mem_q[rd_ptr_q] : '0;
    end

    // Request storage; push is already blocked during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_q[wr_ptr_q]  <= in_a;
            b_mem_q[wr_ptr_q]  <= in_b;
            op_mem_q[wr_ptr_q] <= in_op;
        end
    end

    // Control state and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] ops_done_q, ops_done_d, stall_cycles_q, stall_cycles_d;

    // Completed handshakes (a flush voids the concurrent one) and stalled request cycles.
    always_comb begin
        ops_done_d     = ops_done_q + 16'(res_valid_q && res_ready && !flush);
        stall_cycles_d = stall_cycles_q + 16'(in_valid && !in_ready);
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            ops_done_q     <= ops_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign ops_done     = ops_done_q;
    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: randomized and directed scoreboard bench for alu_issue_queue.
module tb_alu_issue_queue;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, res_valid, res_ready;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
    logic [2:0] in_op, alu_op, res_op;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] ops_done, stall_cycles;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic        hold = 1'b0;
    logic [7:0]  hold_data;
    logic [2:0]  hold_op;
    logic        pdone;

    always #5 clk = ~clk;

    // ALU model: sum of operands, opcode ignored.
    assign alu_out = alu_a + alu_b;

    alu_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op)
`ifdef ALU_ISSUE_STATS_EN
        , .ops_done(ops_done), .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = in_ready;
            tick();
        end
        if (!acc) chk("push_timeout", 32'(acc), 1);
    endtask

    task automatic drain;
        for (int n = 0; n < 200 && (exp_q.size() != 0 || res_valid); n++) tick();
        chk("drain_done", 32'(exp_q.size() == 0 && !res_valid), 1);
    endtask

    // Monitor: reference queue of expected results, hold-stability while stalled.
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst || flush) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_data", 32'(res_data), 32'(hold_data));
                chk("hold_op", 32'(res_op), 32'(hold_op));
            end
            if (res_valid && res_ready) begin
                chk("result_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(e[7:0]));
                    chk("res_op", 32'(res_op), 32'(e[10:8]));
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_op, 8'((int'(in_a) + int'(in_b)) % 256)});
            hold = res_valid && !res_ready;
            hold_data = res_data;
            hold_op = res_op;
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_op", 32'(res_op), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // single op latency
        res_ready = 1'b1;
        push(8'h12, 8'h34, 3'd3);
        in_valid = 1'b0;
        chk("lat_pre_valid", 32'(res_valid), 0);
        chk("alu_a_head", 32'(alu_a), 32'h12);
        chk("alu_op_head", 32'(alu_op), 3);
        tick();
        chk("lat_valid", 32'(res_valid), 1);
        chk("lat_data", 32'(res_data), 32'h46);
        chk("lat_op", 32'(res_op), 3);
        tick();
        chk("lat_drop", 32'(res_valid), 0);

        // fill and backpressure
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i), 8'h01, 3'(i));
        in_a = 8'd5; in_op = 3'd5;
        chk("full_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_data", 32'(res_data), 32'h01);
        end
        res_ready = 1'b1;
        push(8'd5, 8'h01, 3'd5);
        in_valid = 1'b0;
        drain();

        // wrap and throughput
        for (int i = 0; i < 10; i++) begin
            push(8'hF0 + 8'(i), 8'h20, 3'(i % 8));
            if (i > 0) chk("thru_valid", 32'(res_valid), 1);
        end
        in_valid = 1'b0;
        tick();
        chk("thru_last", 32'(res_valid), 1);
        chk("thru_last_data", 32'(res_data), 32'h19);
        tick();
        chk("thru_end", 32'(res_valid), 0);

        // random res_ready toggling
        pdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(8'($urandom), 8'($urandom), 3'($urandom));
                in_valid = 1'b0;
                pdone = 1'b1;
            end
            begin
                for (int n = 0; n < 400 && !pdone; n++) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        res_ready = 1'b1;
        drain();

        // flush with queued work and a held result
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 8'h02, 3'(i));
        in_valid = 1'b0;
        chk("pre_flush_valid", 32'(res_valid), 1);
        flush = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_res_valid", 32'(res_valid), 0);
        chk("flush_in_ready_after", 32'(in_ready), 1);
        push(8'h01, 8'h02, 3'd5);
        in_valid = 1'b0;
        drain();
        repeat (4) tick();

        // reset mid-stream
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 8'h03, 3'(i));
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_data", 32'(res_data), 0);
        chk("mid_rst_op", 32'(res_op), 0);
        chk("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        res_ready = 1'b1;
        repeat (4) tick();
        chk("no_stale", 32'(res_valid), 0);
        push(8'h10, 8'h20, 3'd2);
        in_valid = 1'b0;
        drain();

`ifdef ALU_ISSUE_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stats_rst_ops", 32'(ops_done), 0);
        chk("stats_rst_stall", 32'(stall_cycles), 0);
        for (int i = 0; i < 4; i++) push(8'(i), 8'(i), 3'(i));
        in_valid = 1'b0;
        drain();
        chk("stats_ops4", 32'(ops_done), 4);
        chk("stats_stall0", 32'(stall_cycles), 0);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i), 8'h01, 3'(i));
        repeat (3) tick();
        in_valid = 1'b0;
        chk("stats_stall3", 32'(stall_cycles), 3);
        chk("stats_ops_held", 32'(ops_done), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stats_clr_ops", 32'(ops_done), 0);
        chk("stats_clr_stall", 32'(stall_cycles), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
